// File: rtl/nbyone_stream_multiplexer.sv
// N-to-1 stream multiplexer with a registered output, valid/ready handshake on every
// channel, and either an external select or a fair round-robin grant.
module nbyone_stream_multiplexer #(
  parameter int n  = 4,
  parameter int CH = 4,
  parameter int SW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH*n-1:0] D_in,
  input  logic [CH-1:0]   V_in,
  output logic [CH-1:0]   R_in,
  input  logic [SW-1:0]   S,
  input  logic            M,
  output logic [n-1:0]    Y,
  output logic            V_out,
  input  logic            R_out,
  output logic [SW-1:0]   CH_out
);

  logic [SW-1:0] last;
  logic [SW-1:0] gidx;
  logic [CH-1:0] grant;
  logic          gvalid;
  logic          load;
  logic          xfer;

  // A new beat may enter on the same edge the held beat leaves.
  assign load = !V_out || R_out;
  assign xfer = gvalid && load && !rst;
  assign R_in = xfer ? grant : '0;

  always_comb begin
    grant  = '0;
    gidx   = '0;
    gvalid = 1'b0;
    if (!M) begin
      if (int'(S) < CH) begin
        if (V_in[S]) begin
          gvalid = 1'b1;
          gidx   = S;
        end
      end
    end else begin
      // Search starts one past the last winner so each valid channel gets its turn.
      for (int k = 1; k <= CH; k++) begin
        if (!gvalid && V_in[(int'(last) + k) % CH]) begin
          gvalid = 1'b1;
          gidx   = SW'((int'(last) + k) % CH);
        end
      end
    end
    if (gvalid) grant[gidx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Y      <= '0;
      V_out  <= 1'b0;
      CH_out <= '0;
      last   <= SW'(CH - 1);
    end else if (xfer) begin
      Y      <= D_in[int'(gidx)*n +: n];
      CH_out <= gidx;
      V_out  <= 1'b1;
      if (M) last <= gidx;
    end else if (R_out) begin
      V_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nbyone_stream_multiplexer.sv
// Directed bench for nbyone_stream_multiplexer: reset, select mode, round-robin,
// backpressure, reset mid-transfer and mode switching.
module tb_nbyone_stream_multiplexer;
  localparam int n = 4, CH = 4, SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH*n-1:0] D_in;
  logic [CH-1:0]   V_in;
  logic [CH-1:0]   R_in;
  logic [SW-1:0]   S;
  logic            M;
  logic [n-1:0]    Y;
  logic            V_out;
  logic            R_out;
  logic [SW-1:0]   CH_out;

  int checks = 0;
  int errors = 0;

  nbyone_stream_multiplexer #(.n(n), .CH(CH), .SW(SW)) dut (
    .clk(clk), .rst(rst), .D_in(D_in), .V_in(V_in), .R_in(R_in), .S(S), .M(M),
    .Y(Y), .V_out(V_out), .R_out(R_out), .CH_out(CH_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; M = 1'b1; S = '0; V_in = 4'b1111; R_out = 1'b1;
    tick(); tick();
    checks++; if (V_out !== 1'b0) begin errors++; $display("FAIL reset_vout got %b exp 0", V_out); end
    checks++; if (Y !== 4'h0) begin errors++; $display("FAIL reset_y got %h exp 0", Y); end
    checks++; if (CH_out !== 2'd0) begin errors++; $display("FAIL reset_ch got %0d exp 0", CH_out); end
    checks++; if (R_in !== 4'b0000) begin errors++; $display("FAIL reset_rin got %b exp 0000", R_in); end
    rst = 1'b0;
    #1;
    checks++; if (R_in !== 4'b0001) begin errors++; $display("FAIL reset_rel_rin got %b exp 0001", R_in); end
    tick();
    checks++; if (CH_out !== 2'd0 || Y !== 4'h1 || V_out !== 1'b1) begin
      errors++; $display("FAIL reset_first_beat got ch=%0d y=%h v=%b exp ch=0 y=1 v=1", CH_out, Y, V_out);
    end
  endtask

  task automatic test_select;
    M = 1'b0; S = 2'd2; V_in = 4'b1111; R_out = 1'b1;
    #1;
    checks++; if (R_in !== 4'b0100) begin errors++; $display("FAIL sel_rin got %b exp 0100", R_in); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (Y !== 4'h3 || CH_out !== 2'd2 || V_out !== 1'b1) begin
        errors++; $display("FAIL sel_beat%0d got y=%h ch=%0d v=%b exp y=3 ch=2 v=1", i, Y, CH_out, V_out);
      end
    end
    V_in = 4'b1011;
    #1;
    checks++; if (R_in !== 4'b0000) begin errors++; $display("FAIL sel_novalid_rin got %b exp 0000", R_in); end
    tick();
    checks++; if (V_out !== 1'b0) begin errors++; $display("FAIL sel_vout_drop got %b exp 0", V_out); end
  endtask

  task automatic test_round_robin;
    logic [SW-1:0] exp_seq [6];
    exp_seq = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    M = 1'b1; V_in = 4'b1011; R_out = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (CH_out !== exp_seq[i] || Y !== 4'(exp_seq[i]) + 4'h1 || V_out !== 1'b1) begin
        errors++; $display("FAIL rr_seq%0d got ch=%0d y=%h exp ch=%0d", i, CH_out, Y, exp_seq[i]);
      end
    end
    V_in = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (R_in !== 4'b0100) begin errors++; $display("FAIL rr_single_rin%0d got %b exp 0100", i, R_in); end
      tick();
      checks++; if (CH_out !== 2'd2 || Y !== 4'h3) begin
        errors++; $display("FAIL rr_single%0d got ch=%0d y=%h exp ch=2 y=3", i, CH_out, Y);
      end
    end
  endtask

  task automatic test_backpressure;
    M = 1'b1; V_in = 4'b1111; R_out = 1'b1;
    do_reset();
    tick();
    checks++; if (CH_out !== 2'd0 || Y !== 4'h1) begin errors++; $display("FAIL bp_first got ch=%0d y=%h exp ch=0 y=1", CH_out, Y); end
    R_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (R_in !== 4'b0000) begin errors++; $display("FAIL bp_rin%0d got %b exp 0000", i, R_in); end
      tick();
      checks++; if (CH_out !== 2'd0 || Y !== 4'h1 || V_out !== 1'b1) begin
        errors++; $display("FAIL bp_hold%0d got ch=%0d y=%h v=%b exp ch=0 y=1 v=1", i, CH_out, Y, V_out);
      end
    end
    R_out = 1'b1;
    #1;
    checks++; if (R_in !== 4'b0010) begin errors++; $display("FAIL bp_release_rin got %b exp 0010", R_in); end
    tick();
    checks++; if (CH_out !== 2'd1 || Y !== 4'h2 || V_out !== 1'b1) begin
      errors++; $display("FAIL bp_next got ch=%0d y=%h v=%b exp ch=1 y=2 v=1", CH_out, Y, V_out);
    end
  endtask

  task automatic test_reset_mid;
    M = 1'b1; V_in = 4'b0100; R_out = 1'b1;
    do_reset();
    tick();
    checks++; if (CH_out !== 2'd2) begin errors++; $display("FAIL mid_pre got ch=%0d exp 2", CH_out); end
    R_out = 1'b0; V_in = 4'b1111;
    tick();
    checks++; if (V_out !== 1'b1 || CH_out !== 2'd2) begin errors++; $display("FAIL mid_hold got v=%b ch=%0d exp v=1 ch=2", V_out, CH_out); end
    rst = 1'b1;
    tick();
    checks++; if (V_out !== 1'b0 || Y !== 4'h0 || CH_out !== 2'd0) begin
      errors++; $display("FAIL mid_reset got v=%b y=%h ch=%0d exp v=0 y=0 ch=0", V_out, Y, CH_out);
    end
    rst = 1'b0; R_out = 1'b1;
    tick();
    checks++; if (CH_out !== 2'd0 || V_out !== 1'b1) begin errors++; $display("FAIL mid_restart got ch=%0d v=%b exp ch=0 v=1", CH_out, V_out); end
  endtask

  task automatic test_mode_switch;
    logic [SW-1:0] exp_seq [5];
    logic          m_seq   [5];
    exp_seq = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd2};
    m_seq   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    V_in = 4'b1111; R_out = 1'b1; S = 2'd3; M = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      M = m_seq[i];
      tick();
      checks++; if (CH_out !== exp_seq[i] || Y !== 4'(exp_seq[i]) + 4'h1) begin
        errors++; $display("FAIL mode_seq%0d got ch=%0d y=%h exp ch=%0d", i, CH_out, Y, exp_seq[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; D_in = 16'h4321; V_in = '0; S = '0; M = 1'b0; R_out = 1'b0;
    test_reset();
    test_select();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_mode_switch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
